ir_queue: RTL and testbench
===========================

IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter DATA_W, default 32: instruction width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-003 Parameter OPC_W, default 5: opcode field width; REG_W, default 4: register-index field width.
REQ-004 Clock  in  1  sole clock, all state changes on its rising edge.
REQ-005 Clear  in  1  asynchronous, active-low reset.
REQ-006 BusMuxOut  in  DATA_W  instruction from the bus; IRin  in  1  push request.
REQ-007 IRtake  in  1  pop request; Flush  in  1  synchronous queue discard.
REQ-008 InReady  out  1  push will be accepted this cycle; IRvalid  out  1  head entry present.
REQ-009 IR  out  DATA_W  head instruction; Opcode  out  OPC_W; Ra, Rb, Rc  out  REG_W each; C  out  DATA_W-OPC_W-3*REG_W.
REQ-010 Cext  out  DATA_W  C extended to DATA_W, see Configuration.
REQ-011 Count  out  $clog2(DEPTH+1)  occupancy; Overflow  out  1  sticky dropped-push flag.

Function
REQ-012 Field map of head: Opcode=IR[DATA_W-1 -: OPC_W], Ra next REG_W bits, then Rb, then Rc, C = remaining low bits (DATA_W=32: 31:27, 26:23, 22:19, 18:15, 14:0).
REQ-013 Storage: circular buffer, DEPTH entries, read/write pointers wrap from DEPTH-1 to 0.
REQ-014 InReady = (Count<DEPTH) or (IRtake and IRvalid); purely combinational.
REQ-015 Push occurs when IRin and InReady and not Flush; entry written at write pointer, Count+1.
REQ-016 Pop occurs when IRtake and IRvalid and not Flush; read pointer advances, Count-1.
REQ-017 Push and pop same cycle: Count unchanged, both pointers advance; legal when full.
REQ-018 IRtake with queue empty: ignored, no state change.
REQ-019 IRin when InReady=0 and not Flush: push dropped, Overflow set next edge.
REQ-020 Flush: pointers and Count to 0 next edge; simultaneous IRin/IRtake ignored; Overflow cleared.
REQ-021 Latency: pushed word visible on IR one cycle after push edge when queue was empty; no same-cycle bypass.
REQ-022 IRvalid = (Count!=0); IR and fields show head entry, value undefined-but-stable-zero when empty (outputs driven 0 when IRvalid=0).
REQ-023 Overflow, once set, holds until Flush or Clear.

Reset
REQ-024 Clear low: asynchronously Count=0, pointers=0, Overflow=0, all entries=0; IRvalid=0, IR and all fields=0, InReady=1.
REQ-025 Clear asserted mid-operation discards all contents; first push after release lands in entry 0.
REQ-026 Clear release synchronous to Clock is the integrator's responsibility.

Configuration
REQ-027 Macro IR_QUEUE_SIGNEXT_EN defined: Cext = C sign-extended from its MSB to DATA_W.
REQ-028 Macro undefined: Cext = C zero-extended to DATA_W; no other behaviour changes.

Structure
REQ-029 Shared package ir_pkg holds OPC_W, REG_W, default DATA_W, derived C width, and opcode enumeration constants.
REQ-030 One combinational sub-module ir_field_decode: takes head word, produces Opcode, Ra, Rb, Rc, C, Cext; the macro applies only inside it.
REQ-031 Entries are plain registers (no RAM macro); no other sub-modules.

Verification
REQ-032 Clear low, then push 0x0A9C_0005 -> next cycle IRvalid=1, Opcode=0x01, Ra=5, Rb=3, Rc=8, C=0x0005, Count=1.
REQ-033 Push 4 words, no takes (DEPTH=4) -> Count=4, InReady=0; 5th IRin -> dropped, Overflow=1, head unchanged.
REQ-034 Full queue, IRin and IRtake same cycle with word 0x1234_5678 -> Count stays 4, head advances, new word emerges after three further pops.
REQ-035 Push 6 and pop 6 interleaved -> pointers wrap, words emerge in push order, Count returns 0, IRvalid=0.
REQ-036 Count=3, Flush with IRin and IRtake high -> next cycle Count=0, IRvalid=0, Overflow=0, pushed word absent.
REQ-037 Head C=0x4000: with IR_QUEUE_SIGNEXT_EN -> Cext=0xFFFF_C000; without -> Cext=0x0000_4000.

Source files
------------

// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the instruction-register queue: field widths of the
// instruction word, default word width, derived constant-field width and the
// opcode enumeration.
// ----------------------------------------------------------------------------
package ir_pkg;

    localparam int IR_DATA_W = 32;
    localparam int IR_OPC_W  = 5;
    localparam int IR_REG_W  = 4;
    localparam int IR_C_W    = IR_DATA_W - IR_OPC_W - 3 * IR_REG_W;

    typedef enum logic [IR_OPC_W-1:0] {
        OPC_LD   = 5'h00,
        OPC_LDI  = 5'h01,
        OPC_ST   = 5'h02,
        OPC_ADD  = 5'h03,
        OPC_SUB  = 5'h04,
        OPC_AND  = 5'h05,
        OPC_OR   = 5'h06,
        OPC_SHR  = 5'h07,
        OPC_SHL  = 5'h08,
        OPC_ROR  = 5'h09,
        OPC_ROL  = 5'h0A,
        OPC_ADDI = 5'h0B,
        OPC_ANDI = 5'h0C,
        OPC_ORI  = 5'h0D,
        OPC_MUL  = 5'h0E,
        OPC_DIV  = 5'h0F,
        OPC_NEG  = 5'h10,
        OPC_NOT  = 5'h11,
        OPC_BR   = 5'h12,
        OPC_JR   = 5'h13,
        OPC_JAL  = 5'h14,
        OPC_IN   = 5'h15,
        OPC_OUT  = 5'h16,
        OPC_MFHI = 5'h17,
        OPC_MFLO = 5'h18,
        OPC_NOP  = 5'h19,
        OPC_HALT = 5'h1A
    } opcode_e;

endpackage

// File: rtl/ir_field_decode.sv
// ----------------------------------------------------------------------------
// ir_field_decode
// Splits the head instruction word into its fields and widens the constant.
// Build option: define IR_QUEUE_SIGNEXT_EN to sign-extend C into Cext;
// otherwise C is zero-extended.
//
// Ports
//   head   in   DATA_W        instruction word to decode
//   opcode out  OPC_W         head[DATA_W-1 -: OPC_W]
//   ra     out  REG_W         next REG_W bits below the opcode
//   rb     out  REG_W         next REG_W bits below ra
//   rc     out  REG_W         next REG_W bits below rb
//   c      out  C_W           remaining low bits
//   cext   out  DATA_W        c widened to DATA_W
// ----------------------------------------------------------------------------
module ir_field_decode
    import ir_pkg::*;
#(
    parameter int DATA_W = IR_DATA_W,
    parameter int OPC_W  = IR_OPC_W,
    parameter int REG_W  = IR_REG_W,
    parameter int C_W    = DATA_W - OPC_W - 3 * REG_W
) (
    input  logic [DATA_W-1:0] head,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  ra,
    output logic [REG_W-1:0]  rb,
    output logic [REG_W-1:0]  rc,
    output logic [C_W-1:0]    c,
    output logic [DATA_W-1:0] cext
);

    assign opcode = head[DATA_W-1 -: OPC_W];
    assign ra     = head[DATA_W-OPC_W-1 -: REG_W];
    assign rb     = head[DATA_W-OPC_W-REG_W-1 -: REG_W];
    assign rc     = head[DATA_W-OPC_W-2*REG_W-1 -: REG_W];
    assign c      = head[C_W-1:0];

`ifdef IR_QUEUE_SIGNEXT_EN
    logic signed [C_W-1:0] c_s;

    assign c_s  = c;
    assign cext = DATA_W'(c_s);
`else
    assign cext = {{(DATA_W-C_W){1'b0}}, c};
`endif

endmodule

// File: rtl/ir_queue.sv
// ----------------------------------------------------------------------------
// ir_queue
// Instruction-register queue: a DEPTH-entry circular buffer of instruction
// words fed from the bus, presenting the head entry and its decoded fields.
// Build option: IR_QUEUE_SIGNEXT_EN (applied inside ir_field_decode) selects
// sign- instead of zero-extension of the C field onto Cext.
//
// Ports
//   Clock     in   1          rising-edge clock
//   Clear     in   1          asynchronous active-low reset
//   BusMuxOut in   DATA_W     instruction to push
//   IRin      in   1          push request
//   IRtake    in   1          pop request
//   Flush     in   1          synchronous discard of all entries
//   InReady   out  1          a push would be accepted this cycle
//   IRvalid   out  1          head entry present
//   IR        out  DATA_W     head instruction (0 when empty)
//   Opcode, Ra, Rb, Rc, C     decoded head fields (0 when empty)
//   Cext      out  DATA_W     C widened to DATA_W
//   Count     out  clog2(DEPTH+1)  occupancy
//   Overflow  out  1          sticky flag: a push was dropped
// ----------------------------------------------------------------------------
module ir_queue
    import ir_pkg::*;
#(
    parameter int DATA_W = IR_DATA_W,
    parameter int DEPTH  = 4,
    parameter int OPC_W  = IR_OPC_W,
    parameter int REG_W  = IR_REG_W
) (
    input  logic                            Clock,
    input  logic                            Clear,
    input  logic [DATA_W-1:0]               BusMuxOut,
    input  logic                            IRin,
    input  logic                            IRtake,
    input  logic                            Flush,
    output logic                            InReady,
    output logic                            IRvalid,
    output logic [DATA_W-1:0]               IR,
    output logic [OPC_W-1:0]                Opcode,
    output logic [REG_W-1:0]                Ra,
    output logic [REG_W-1:0]                Rb,
    output logic [REG_W-1:0]                Rc,
    output logic [DATA_W-OPC_W-3*REG_W-1:0] C,
    output logic [DATA_W-1:0]               Cext,
    output logic [$clog2(DEPTH+1)-1:0]      Count,
    output logic                            Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int C_W   = DATA_W - OPC_W - 3 * REG_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign IRvalid = (cnt != '0);
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign InReady = (cnt < CNT_W'(DEPTH)) || (IRtake && IRvalid);
    assign push    = IRin && InReady && !Flush;
    assign pop     = IRtake && IRvalid && !Flush;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= BusMuxOut;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (IRin && !InReady) begin
                ovf <= 1'b1;
            end
        end
    end

    // Stale storage is masked so every head-derived output reads 0 when empty.
    assign head     = IRvalid ? mem[rd_ptr] : '0;
    assign IR       = head;
    assign Count    = cnt;
    assign Overflow = ovf;

    ir_field_decode #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .REG_W  (REG_W),
        .C_W    (C_W)
    ) u_decode (
        .head   (head),
        .opcode (Opcode),
        .ra     (Ra),
        .rb     (Rb),
        .rc     (Rc),
        .c      (C),
        .cext   (Cext)
    );

endmodule

// File: tb/tb_ir_queue.sv
// ----------------------------------------------------------------------------
// tb_ir_queue
// Directed bench for ir_queue (DATA_W=32, DEPTH=4) with hand-computed
// expected values.
// ----------------------------------------------------------------------------
module tb_ir_queue;

    logic        Clock;
    logic        Clear;
    logic [31:0] BusMuxOut;
    logic        IRin;
    logic        IRtake;
    logic        Flush;
    logic        InReady;
    logic        IRvalid;
    logic [31:0] IR;
    logic [4:0]  Opcode;
    logic [3:0]  Ra;
    logic [3:0]  Rb;
    logic [3:0]  Rc;
    logic [14:0] C;
    logic [31:0] Cext;
    logic [2:0]  Count;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    ir_queue #(
        .DATA_W (32),
        .DEPTH  (4),
        .OPC_W  (5),
        .REG_W  (4)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .BusMuxOut (BusMuxOut),
        .IRin      (IRin),
        .IRtake    (IRtake),
        .Flush     (Flush),
        .InReady   (InReady),
        .IRvalid   (IRvalid),
        .IR        (IR),
        .Opcode    (Opcode),
        .Ra        (Ra),
        .Rb        (Rb),
        .Rc        (Rc),
        .C         (C),
        .Cext      (Cext),
        .Count     (Count),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then examined 1 time unit after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        BusMuxOut = w;
        IRin      = 1'b1;
        tick();
        IRin      = 1'b0;
    endtask

    task automatic pop();
        IRtake = 1'b1;
        tick();
        IRtake = 1'b0;
    endtask

    task automatic push_pop(input logic [31:0] w);
        BusMuxOut = w;
        IRin      = 1'b1;
        IRtake    = 1'b1;
        tick();
        IRin      = 1'b0;
        IRtake    = 1'b0;
    endtask

    task automatic flush();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
    endtask

    logic [31:0] words [6];
    logic [31:0] cext_exp;

    initial begin
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003;
        words[3] = 32'h4444_0004;
        words[4] = 32'h5555_0005;
        words[5] = 32'h6666_0006;

        Clear     = 1'b0;
        BusMuxOut = '0;
        IRin      = 1'b0;
        IRtake    = 1'b0;
        Flush     = 1'b0;

        // Reset state
        #12;
        chk("rst_count",   64'(Count),    64'd0);
        chk("rst_irvalid", 64'(IRvalid),  64'd0);
        chk("rst_inready", 64'(InReady),  64'd1);
        chk("rst_ir",      64'(IR),       64'd0);
        chk("rst_ovf",     64'(Overflow), 64'd0);
        #10;
        Clear = 1'b1;
        tick();

        // Decode of first word; no same-cycle bypass
        BusMuxOut = 32'h0A9C_0005;
        IRin      = 1'b1;
        #1;
        chk("nobypass_irvalid", 64'(IRvalid), 64'd0);
        tick();
        IRin = 1'b0;
        chk("dec_irvalid", 64'(IRvalid), 64'd1);
        chk("dec_opcode",  64'(Opcode),  64'h01);
        chk("dec_ra",      64'(Ra),      64'd5);
        chk("dec_rb",      64'(Rb),      64'd3);
        chk("dec_rc",      64'(Rc),      64'd8);
        chk("dec_c",       64'(C),       64'h0005);
        chk("dec_cext",    64'(Cext),    64'h0000_0005);
        chk("dec_count",   64'(Count),   64'd1);
        flush();
        chk("flush1_count", 64'(Count), 64'd0);

        // Fill, then a dropped fifth push
        for (int i = 0; i < 4; i++) push(words[i]);
        chk("full_count",   64'(Count),   64'd4);
        chk("full_inready", 64'(InReady), 64'd0);
        chk("full_head",    64'(IR),      64'(words[0]));
        push(32'hDEAD_BEEF);
        chk("drop_ovf",   64'(Overflow), 64'd1);
        chk("drop_count", 64'(Count),    64'd4);
        chk("drop_head",  64'(IR),       64'(words[0]));

        // Simultaneous push and pop on a full queue
        IRtake = 1'b1;
        #1;
        chk("full_take_inready", 64'(InReady), 64'd1);
        IRtake = 1'b0;
        push_pop(32'h1234_5678);
        chk("pp_count", 64'(Count), 64'd4);
        chk("pp_head",  64'(IR),    64'(words[1]));
        pop();
        chk("pp_head2", 64'(IR), 64'(words[2]));
        pop();
        chk("pp_head3", 64'(IR), 64'(words[3]));
        pop();
        chk("pp_head4",     64'(IR),       64'h1234_5678);
        chk("ovf_sticky",   64'(Overflow), 64'd1);
        pop();
        chk("empty_count",   64'(Count),   64'd0);
        chk("empty_irvalid", 64'(IRvalid), 64'd0);
        chk("empty_ir",      64'(IR),      64'd0);
        pop();
        chk("take_empty_count", 64'(Count), 64'd0);
        flush();
        chk("flush_ovf", 64'(Overflow), 64'd0);

        // Interleaved 6 pushes / 6 pops with pointer wrap
        push(words[0]);
        push(words[1]);
        for (int i = 2; i < 6; i++) begin
            push_pop(words[i]);
            chk($sformatf("wrap_head%0d", i), 64'(IR),    64'(words[i-1]));
            chk($sformatf("wrap_cnt%0d", i),  64'(Count), 64'd2);
        end
        pop();
        chk("wrap_head_last", 64'(IR), 64'(words[5]));
        pop();
        chk("wrap_count",   64'(Count),   64'd0);
        chk("wrap_irvalid", 64'(IRvalid), 64'd0);

        // Flush with simultaneous push and pop at Count=3, Overflow set
        for (int i = 0; i < 4; i++) push(words[i]);
        push(32'hDEAD_BEEF);
        pop();
        chk("pre_flush_count", 64'(Count),    64'd3);
        chk("pre_flush_ovf",   64'(Overflow), 64'd1);
        BusMuxOut = 32'hBAD0_BAD0;
        IRin      = 1'b1;
        IRtake    = 1'b1;
        Flush     = 1'b1;
        tick();
        IRin   = 1'b0;
        IRtake = 1'b0;
        Flush  = 1'b0;
        chk("flush_count",   64'(Count),    64'd0);
        chk("flush_irvalid", 64'(IRvalid),  64'd0);
        chk("flush_ovf2",    64'(Overflow), 64'd0);
        push(32'h0A9C_0005);
        chk("flush_absent", 64'(IR), 64'h0A9C_0005);
        pop();

        // C extension
        push(32'h0000_4000);
`ifdef IR_QUEUE_SIGNEXT_EN
        cext_exp = 32'hFFFF_C000;
`else
        cext_exp = 32'h0000_4000;
`endif
        chk("ext_c",    64'(C),    64'h4000);
        chk("ext_cext", 64'(Cext), 64'(cext_exp));

        // Asynchronous Clear mid-operation
        push(words[4]);
        #3;
        Clear = 1'b0;
        #1;
        chk("aclr_count",   64'(Count),   64'd0);
        chk("aclr_irvalid", 64'(IRvalid), 64'd0);
        chk("aclr_ir",      64'(IR),      64'd0);
        @(negedge Clock);
        Clear = 1'b1;
        tick();
        push(words[5]);
        chk("aclr_push_head",  64'(IR),    64'(words[5]));
        chk("aclr_push_count", 64'(Count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
